// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } pipe_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else count <= clr ? '0 : (inc && !(&count)) ? count + W'(1) : count;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with optional 2-entry skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   stall_cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e      stateQ, stateD;
    logic [WIDTH-1:0] mainQ, skidQ;
    logic             inReadyQ, accept, pop, loadMain, loadSkid, promote;

    // without a skid entry the stage only reaches TWO if it accepts while full,
    // which the combinational ready forbids, so one FSM serves both modes
    assign in_ready  = SKID ? inReadyQ : (stateQ == EMPTY || out_ready);
    assign out_valid = stateQ != EMPTY;
    assign out_data  = mainQ;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // next state and payload load enables; flush squashes everything
    always_comb begin
        stateD   = stateQ;
        loadMain = 1'b0;
        loadSkid = 1'b0;
        promote  = 1'b0;
        case (stateQ)
            EMPTY: begin
                stateD   = accept ? ONE : EMPTY;
                loadMain = accept;
            end
            ONE: begin
                stateD   = (accept && !pop) ? TWO : (pop && !accept) ? EMPTY : ONE;
                loadMain = accept && pop;
                loadSkid = accept && !pop;
            end
            TWO: begin
                stateD  = pop ? ONE : TWO;
                promote = pop;
            end
            default: stateD = EMPTY;
        endcase
        if (flush) begin
            stateD   = EMPTY;
            loadMain = 1'b0;
            loadSkid = 1'b0;
            promote  = 1'b0;
        end
    end

    // state, registered ready and payload entries
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stateQ   <= EMPTY;
            inReadyQ <= 1'b1;
            mainQ    <= RESET_VAL;
            skidQ    <= RESET_VAL;
        end else begin
            stateQ   <= stateD;
            inReadyQ <= stateD != TWO;
            mainQ    <= loadMain ? in_data : promote ? skidQ : mainQ;
            skidQ    <= loadSkid ? in_data : skidQ;
        end

    pipe_sat_counter #(
        .W(STALL_CNT_W)
    ) u_stallCnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && !out_ready),
        .clr  (stall_cnt_clr),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for skid and non-skid stage registers
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, inValid, flush, outReady, stallClr;
    logic [15:0] inData;
    logic        rdy1, vld1, rdy0, vld0;
    logic [15:0] dat1, dat0, cnt1, cnt0;

    logic [15:0] q1[$];
    logic [15:0] q0[$];
    logic [15:0] main1 = 16'h5A5A;
    logic [15:0] main0 = 16'h0000;
    logic [15:0] nextVal;
    int          stall1 = 0, stall0 = 0;
    int          checks = 0, failures = 0;
    bit          lastAcc1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(16), .RESET_VAL(16'h5A5A), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy1), .in_data(inData),
        .flush(flush), .out_valid(vld1), .out_ready(outReady), .out_data(dat1),
        .stall_cnt_clr(stallClr), .stall_cnt(cnt1)
    );

    pipe_stage_reg #(.WIDTH(16), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdy0), .in_data(inData),
        .flush(flush), .out_valid(vld0), .out_ready(outReady), .out_data(dat0),
        .stall_cnt_clr(stallClr), .stall_cnt(cnt0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit chk = 1'b1);
        bit er1, ev1, er0, ev0, acc1, acc0, pop1, pop0;
        @(negedge clk);
        ev1 = q1.size() > 0;
        er1 = q1.size() < 2;
        ev0 = q0.size() > 0;
        er0 = !ev0 || outReady;
        if (chk) begin
            check("rdy1", {15'b0, rdy1}, {15'b0, er1});
            check("vld1", {15'b0, vld1}, {15'b0, ev1});
            check("dat1", dat1, main1);
            check("cnt1", cnt1, 16'(stall1));
            check("rdy0", {15'b0, rdy0}, {15'b0, er0});
            check("vld0", {15'b0, vld0}, {15'b0, ev0});
            check("dat0", dat0, main0);
            check("cnt0", cnt0, 16'(stall0));
        end
        acc1 = inValid && er1;
        pop1 = ev1 && outReady;
        acc0 = inValid && er0;
        pop0 = ev0 && outReady;
        @(posedge clk);
        if (flush) q1.delete();
        else begin
            if (pop1) void'(q1.pop_front());
            if (acc1) q1.push_back(inData);
        end
        if (flush) q0.delete();
        else begin
            if (pop0) void'(q0.pop_front());
            if (acc0) q0.push_back(inData);
        end
        if (q1.size() > 0) main1 = q1[0];
        if (q0.size() > 0) main0 = q0[0];
        stall1 = stallClr ? 0 : (ev1 && !outReady && stall1 < 65535) ? stall1 + 1 : stall1;
        stall0 = stallClr ? 0 : (ev0 && !outReady && stall0 < 65535) ? stall0 + 1 : stall0;
        lastAcc1 = acc1 && !flush;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; inValid = 1'b1; inData = 16'h1234; flush = 1'b0; outReady = 1'b0; stallClr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstVld1", {15'b0, vld1}, 16'h0);
        check("rstDat1", dat1, 16'h5A5A);
        check("rstCnt1", cnt1, 16'h0);
        check("rstVld0", {15'b0, vld0}, 16'h0);
        check("rstDat0", dat0, 16'h0);
        inValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstRdy1", {15'b0, rdy1}, 16'h1);
        check("rstRdy0", {15'b0, rdy0}, 16'h1);

        outReady = 1'b1;
        inValid = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            inData = 16'(v);
            tick();
            if (v == 1) begin
                check("latVld", {15'b0, vld1}, 16'h1);
                check("latDat", dat1, 16'h0001);
            end
        end
        inValid = 1'b0;
        repeat (2) tick();
        check("streamCnt", cnt1, 16'h0);

        nextVal = 16'h0011;
        inValid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            outReady = !(i >= 3 && i < 8);
            inData = nextVal;
            tick();
            if (lastAcc1) nextVal++;
            if (i == 3) check("bpRdy", {15'b0, rdy1}, 16'h0);
        end
        check("bpStall1", cnt1, 16'd5);
        check("bpStall0", cnt0, 16'd5);
        inValid = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();
        check("bpDrain", {15'b0, vld1}, 16'h0);

        outReady = 1'b0;
        inValid = 1'b1;
        inData = 16'hAAAA;
        tick();
        inData = 16'hBBBB;
        tick();
        check("twoRdy", {15'b0, rdy1}, 16'h0);
        flush = 1'b1;
        inData = 16'hCCCC;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        check("flushVld1", {15'b0, vld1}, 16'h0);
        check("flushVld0", {15'b0, vld0}, 16'h0);
        check("flushDat1", dat1, 16'hAAAA);
        tick();

        inValid = 1'b1;
        inData = 16'h1111;
        tick();
        check("s0RdyLow", {15'b0, rdy0}, 16'h0);
        outReady = 1'b1;
        #1;
        check("s0RdyHigh", {15'b0, rdy0}, 16'h1);
        inData = 16'h2222;
        tick();
        check("s0Vld", {15'b0, vld0}, 16'h1);
        check("s0Dat", dat0, 16'h2222);

        #2;
        rst = 1'b0;
        #1;
        check("arstVld1", {15'b0, vld1}, 16'h0);
        check("arstVld0", {15'b0, vld0}, 16'h0);
        check("arstDat1", dat1, 16'h5A5A);
        check("arstCnt1", cnt1, 16'h0);
        q1.delete();
        q0.delete();
        main1 = 16'h5A5A;
        main0 = 16'h0000;
        stall1 = 0;
        stall0 = 0;
        inValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        inValid = 1'b1;
        inData = 16'h7777;
        outReady = 1'b0;
        tick();
        inValid = 1'b0;
        repeat (70000) tick(1'b0);
        check("satCnt1", cnt1, 16'hFFFF);
        check("satCnt0", cnt0, 16'hFFFF);
        stallClr = 1'b1;
        tick();
        stallClr = 1'b0;
        check("clrCnt1", cnt1, 16'h0);
        check("clrCnt0", cnt0, 16'h0);
        tick();
        check("reCnt1", cnt1, 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
